// File: rtl/reg_bank_param.sv
// Parametrised register bank: byte-enabled write port, clear-all, write-first registered read
// port and a flat parallel view of every register. Out-of-range addresses are flagged, never aliased.
module reg_bank_param #(
   parameter int unsigned       NUM_REGS  = 16,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write_en,
   input  logic [ADDR_W-1:0]            add_line,
   input  logic [DATA_W-1:0]            data_in,
   input  logic [DATA_W/8-1:0]          byte_en,
   input  logic                         clear,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic                         wr_err,
   output logic                         rd_err,
   output logic [NUM_REGS*DATA_W-1:0]   data_out
);

   localparam int unsigned NB = DATA_W / 8;

   generate
      if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
         $fatal(1, "reg_bank_param: DATA_W must be a non-zero multiple of 8");
      end
      if (NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_num_regs
         $fatal(1, "reg_bank_param: NUM_REGS must be in 2..256");
      end
      if (ADDR_W < $clog2(NUM_REGS)) begin : g_bad_addr_w
         $fatal(1, "reg_bank_param: ADDR_W too narrow for NUM_REGS");
      end
   endgenerate

   // One extra bit so NUM_REGS == 2**ADDR_W still fits in the bound.
   localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_err_q, wr_err_q;
   logic              wr_hit, rd_hit;

   assign wr_hit = ({1'b0, add_line} < NUM_REGS_A);
   assign rd_hit = ({1'b0, rd_addr}  < NUM_REGS_A);

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (clear) begin
            regs_d[i] = RESET_VAL;
         end else if (write_en && wr_hit && add_line == ADDR_W'(i)) begin
            for (int k = 0; k < NB; k++) begin
               if (byte_en[k]) regs_d[i][8*k +: 8] = data_in[8*k +: 8];
            end
         end
      end
   end

   // Reading the next-state array gives write-first behaviour; out-of-range matches nothing and reads 0.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_data_d = regs_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         if (rd_en) rd_data_q <= rd_data_d;
         rd_valid_q <= rd_en;
         rd_err_q   <= rd_en && !rd_hit;
         wr_err_q   <= write_en && !wr_hit;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign wr_err   = wr_err_q;

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign data_out[g*DATA_W +: DATA_W] = regs_q[g];
      end
   endgenerate

endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param with 12 registers on a 4-bit address, so both
// in-range and out-of-range addresses are exercised; a non-zero reset value is used.
module tb_reg_bank_param;

   localparam int NR = 12;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam logic [DW-1:0] RV = 32'hA5A5_5A5A;

   logic              clk = 1'b0;
   logic              reset, write_en, clear, rd_en;
   logic [AW-1:0]     add_line, rd_addr;
   logic [DW-1:0]     data_in;
   logic [DW/8-1:0]   byte_en;
   logic [DW-1:0]     rd_data;
   logic              rd_valid, wr_err, rd_err;
   logic [NR*DW-1:0]  data_out;

   reg_bank_param #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .RESET_VAL(RV)) dut (
      .clk(clk), .reset(reset), .write_en(write_en), .add_line(add_line),
      .data_in(data_in), .byte_en(byte_en), .clear(clear), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .wr_err(wr_err),
      .rd_err(rd_err), .data_out(data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rv;
      logic             re;
      logic             we;
      logic [DW-1:0]    held;
      logic [NR*DW-1:0] regs;
   } cyc_t;

   typedef struct {
      logic          err;
      logic [DW-1:0] data;
   } rd_t;

   cyc_t          cycq[$];
   rd_t           rdq[$];
   logic [DW-1:0] mdl [NR];
   logic [DW-1:0] last_rd;
   int            errors = 0;
   int            checks = 0;

   task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: registers as a plain array, byte merge by mask arithmetic.
   task automatic step(input logic we, input int a, input logic [DW-1:0] d, input logic [3:0] be,
                       input logic clr, input logic re, input int ra, input logic rst);
      cyc_t          c;
      rd_t           r;
      logic [DW-1:0] nxt [NR];
      logic [DW-1:0] mask;
      @(negedge clk);
      reset = rst; write_en = we; add_line = AW'(a); data_in = d; byte_en = be;
      clear = clr; rd_en = re; rd_addr = AW'(ra);
      c.rv = 1'b0; c.re = 1'b0; c.we = 1'b0;
      if (rst) begin
         for (int i = 0; i < NR; i++) mdl[i] = RV;
         last_rd = '0;
      end else begin
         nxt = mdl;
         mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         if (clr) begin
            for (int i = 0; i < NR; i++) nxt[i] = RV;
         end else if (we && a < NR) begin
            nxt[a] = (nxt[a] & ~mask) | (d & mask);
         end
         c.we = we && (a >= NR);
         c.rv = re;
         c.re = re && (ra >= NR);
         if (re) begin
            r.err  = c.re;
            r.data = (ra < NR) ? nxt[ra] : '0;
            rdq.push_back(r);
            last_rd = r.data;
         end
         mdl = nxt;
      end
      c.held = last_rd;
      for (int i = 0; i < NR; i++) c.regs[i*DW +: DW] = mdl[i];
      cycq.push_back(c);
   endtask

   task automatic idle();
      step(0, 0, '0, 4'h0, 0, 0, 0, 0);
   endtask

   // Monitor: one expectation per clock, read data popped whenever rd_valid is seen.
   initial begin
      cyc_t c;
      rd_t  r;
      forever begin
         @(posedge clk);
         #1;
         if (cycq.size() > 0) begin
            c = cycq.pop_front();
            chk("rd_valid", NR*DW'(rd_valid), NR*DW'(c.rv));
            chk("rd_err", NR*DW'(rd_err), NR*DW'(c.re));
            chk("wr_err", NR*DW'(wr_err), NR*DW'(c.we));
            chk("data_out", data_out, c.regs);
            if (rd_valid === 1'b1) begin
               if (rdq.size() == 0) begin
                  chk("rd_unexpected", NR*DW'(1), NR*DW'(0));
               end else begin
                  r = rdq.pop_front();
                  chk("rd_data", NR*DW'(rd_data), NR*DW'(r.data));
               end
            end else begin
               chk("rd_hold", NR*DW'(rd_data), NR*DW'(c.held));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; write_en = 1'b0; add_line = '0; data_in = '0; byte_en = '0;
      clear = 1'b0; rd_en = 1'b0; rd_addr = '0; last_rd = '0;
      for (int i = 0; i < NR; i++) mdl[i] = RV;

      step(0, 0, '0, 4'h0, 0, 0, 0, 1);
      step(0, 0, '0, 4'h0, 0, 0, 0, 1);
      idle();

      step(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
      step(0, 0, '0, 4'h0, 0, 1, 3, 0);
      idle();

      step(1, 5, 32'h11223344, 4'hF, 0, 0, 0, 0);
      step(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
      step(1, 5, 32'hFFFFFFFF, 4'h0, 0, 1, 5, 0);
      idle();

      step(1, 7, 32'h0000CAFE, 4'hF, 0, 1, 7, 0);
      step(1, 7, 32'h0000CAFE, 4'hF, 1, 1, 7, 0);
      idle();

      step(1, 13, 32'h12345678, 4'hF, 0, 0, 0, 0);
      step(0, 0, '0, 4'h0, 0, 1, 14, 0);
      step(1, 15, 32'h12345678, 4'hF, 1, 1, 11, 0);
      idle();

      for (int i = 0; i < 16; i++) step(1, i, 32'h100 + i, 4'hF, 0, 0, 0, 0);
      step(0, 0, '0, 4'h0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 0, '0, 4'h0, 0, 1, i, 0);
      idle();

      for (int i = 0; i < 4; i++) step(1, i, 32'h5555_0000 + i, 4'hF, 0, 1, i, 0);
      step(1, 2, 32'hFFFF_FFFF, 4'hF, 0, 1, 2, 1);
      idle();
      step(0, 0, '0, 4'h0, 0, 1, 2, 0);

      for (int n = 0; n < 500; n++) begin
         step($urandom_range(0, 1), $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15),
              $urandom_range(0, 99) == 0);
      end

      repeat (3) idle();
      repeat (3) @(posedge clk);
      chk("rd_queue_drained", NR*DW'(rdq.size()), NR*DW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised successor to the team's fixed 16 x 32-bit address-decoded register bank.
- NUM_REGS registers of DATA_W bits each; one shared write port with per-byte enables.
- Synchronous clear-all command, plus a registered random-access read port with write-first bypass.
- All registers are also exposed as a flat parallel bus for downstream control logic.
- Out-of-range accesses are flagged rather than aliased.

Parameters:
- NUM_REGS, 16, number of registers; 2..256.
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; 2**ADDR_W >= NUM_REGS required.
- RESET_VAL, 0, value every register takes on reset or clear; width DATA_W.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  write strobe, qualified by add_line and byte_en.
- add_line  input  ADDR_W  write address.
- data_in  input  DATA_W  write data.
- byte_en  input  DATA_W/8  byte lane enables; bit k covers data_in[8k+7:8k].
- clear  input  1  one-cycle command: load RESET_VAL into all registers.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  high for exactly one cycle, the cycle after an accepted rd_en.
- wr_err  output  1  one-cycle pulse: the previous-cycle write addressed >= NUM_REGS.
- rd_err  output  1  one-cycle pulse, coincident with rd_valid: the read addressed >= NUM_REGS.
- data_out  output  NUM_REGS*DATA_W  flat bus of all registers; reg i = data_out[i*DATA_W +: DATA_W].

Behaviour:
- Reset, synchronous, active-high, checked at the clk edge, highest priority:
  - all registers = RESET_VAL;
  - rd_data = 0, rd_valid = 0, wr_err = 0, rd_err = 0;
  - write, clear and read requests in the reset cycle are discarded.
- Write, when write_en=1 and add_line < NUM_REGS:
  - for each k with byte_en[k]=1, reg[add_line] byte k <= data_in byte k;
  - other bytes hold;
  - byte_en=0 is a legal no-op write (no error).
- Write error, when write_en=1 and add_line >= NUM_REGS:
  - no register changes;
  - wr_err=1 on the next cycle only.
- Clear, when clear=1:
  - all registers <= RESET_VAL at the next edge;
  - clear beats a write in the same cycle, so the write is dropped;
  - wr_err is still reported for an out-of-range address.
- data_out reflects register contents; a write is visible on data_out one cycle after its edge. No combinational path from inputs to data_out.
- Read, when rd_en=1:
  - latency is 1 cycle: rd_valid=1 and rd_data valid on the cycle after rd_en;
  - back-to-back reads every cycle are supported at full throughput.
- Read is write-first. rd_data equals the register's next-state value at the request edge:
  - same-cycle write to the same address returns the byte-merged new value;
  - same-cycle clear returns RESET_VAL;
  - reset has priority over both.
- Out-of-range read (rd_addr >= NUM_REGS): rd_data = 0, rd_valid=1, rd_err=1 on the next cycle.
- rd_en=0: rd_valid=0 and rd_err=0 next cycle; rd_data holds its last value.
- Address comparison uses the full ADDR_W bits. No aliasing or wrap-around of out-of-range addresses onto valid registers.
- Parameter legality is checked at elaboration; an illegal DATA_W or ADDR_W is a fatal error.

Test Plan:
1. Reset, then write_en=1, add_line=3, data_in=0xDEADBEEF, byte_en=4'hF, then rd_en=1, rd_addr=3 → next cycle rd_valid=1, rd_data=0xDEADBEEF; data_out[127:96]=0xDEADBEEF; all other registers 0.
2. reg5=0x11223344, then write data_in=0xAABBCCDD, byte_en=4'b0101 → reg5=0x11BB33DD; no other register changes.
3. Same cycle: write reg7=0x0000CAFE and rd_en with rd_addr=7 → rd_data=0x0000CAFE (bypass). Repeat with clear=1 in that cycle → rd_data=0, reg7=0.
4. NUM_REGS=12, ADDR_W=4: write to add_line=13 → wr_err pulses 1 cycle, data_out unchanged. Read rd_addr=14 → rd_valid=1, rd_err=1, rd_data=0.
5. Fill all 16 registers with 0x100+i, assert clear for 1 cycle → every register = RESET_VAL next cycle. Sweep reads 0..15 back-to-back → 16 consecutive rd_valid pulses.
6. Assert reset mid-stream, with write and read pending that cycle → write dropped, rd_valid=0 next cycle, all registers = RESET_VAL, flags 0.
